// File: rtl/rtc_slew_if.sv
// Signal bundle for rtc_slew: ToD load, period/offset control, capture and time outputs.
// slave = the clock block itself, master = whoever drives and observes it.
interface rtc_slew_if #(
   parameter int SEC_W = 48,
   parameter int FNS_W = 8,
   parameter int PF    = 32
);
   logic                  time_ld;
   logic [30+FNS_W-1:0]   time_ns_in;
   logic [SEC_W-1:0]      time_sec_in;
   logic                  period_ld;
   logic [PF+7:0]         period_in;
   logic                  offset_ld;
   logic [31:0]           offset_ns;
   logic                  offset_busy;
   logic                  offset_done;
   logic                  cap_trig;
   logic                  cap_valid;
   logic [30+FNS_W-1:0]   cap_ns;
   logic [SEC_W-1:0]      cap_sec;
   logic [30+FNS_W-1:0]   time_reg_ns;
   logic [SEC_W-1:0]      time_reg_sec;
   logic [31:0]           time_ptp_ns;
   logic [SEC_W-1:0]      time_ptp_sec;
   logic                  time_one_pps;
   logic                  slew_state;

   modport slave (
      input  time_ld, time_ns_in, time_sec_in, period_ld, period_in,
             offset_ld, offset_ns, cap_trig,
      output offset_busy, offset_done, cap_valid, cap_ns, cap_sec,
             time_reg_ns, time_reg_sec, time_ptp_ns, time_ptp_sec,
             time_one_pps, slew_state
   );

   modport master (
      output time_ld, time_ns_in, time_sec_in, period_ld, period_in,
             offset_ld, offset_ns, cap_trig,
      input  offset_busy, offset_done, cap_valid, cap_ns, cap_sec,
             time_reg_ns, time_reg_sec, time_ptp_ns, time_ptp_sec,
             time_one_pps, slew_state
   );
endinterface

// File: rtl/rtc_slew.sv
// Time-of-day counter: fractional-ns period accumulation with delta-sigma residual,
// bounded-rate offset slewing, timestamp capture and a one-PPS pulse on second rollover.
module rtc_slew #(
   parameter int SEC_W   = 48,
   parameter int FNS_W   = 8,
   parameter int PF      = 32,
   parameter int SLEW_NS = 4,
   parameter int PPS_W   = 4,
   parameter logic [PF+7:0] PERIOD_RST = {8'd8, {PF{1'b0}}}
) (
   input  logic clk,
   input  logic rst,
   rtc_slew_if.slave bus
);
   localparam int NS_W = 30 + FNS_W;
   localparam int RW   = PF - FNS_W;
   localparam int SW   = 8 + FNS_W;
   localparam int AW   = NS_W + 2;
   localparam int PW   = $clog2(PPS_W + 1);
   localparam logic [AW-1:0] NS_MOD = AW'(64'd1000000000 << FNS_W);
   localparam logic signed [31:0] SLEW_MAX = 32'(SLEW_NS);

   typedef enum logic {IDLE = 1'b0, SLEW = 1'b1} state_t;

   state_t            state_q, state_d;
   logic signed [31:0] rem_q, rem_d;
   logic              done_q, done_d;
   logic signed [31:0] slew_s;

   logic [PF+7:0]     period_q;
   logic [RW-1:0]     resid_q;
   logic [NS_W-1:0]   ns_q;
   logic [SEC_W-1:0]  sec_q;
   logic              cap_valid_q;
   logic [NS_W-1:0]   cap_ns_q;
   logic [SEC_W-1:0]  cap_sec_q;
   logic [PW-1:0]     pps_cnt_q;

   logic [RW:0]       resid_sum;
   logic [SW-1:0]     step;
   logic [AW-1:0]     ns_sum;
   logic [AW-1:0]     ns_wrap;
   logic              rollover;

   // Residual carry adds one fine-ns LSB so the long-run rate matches the full period word.
   assign resid_sum = {1'b0, resid_q} + {1'b0, period_q[RW-1:0]};
   assign step      = period_q[PF+7:RW] + SW'(resid_sum[RW]);
   assign ns_sum    = {2'b00, ns_q} + AW'(step)
                    + ({{(AW-32){slew_s[31]}}, slew_s} << FNS_W);
   assign rollover  = (ns_sum >= NS_MOD) && !bus.time_ld;
   assign ns_wrap   = (ns_sum >= NS_MOD) ? (ns_sum - NS_MOD) : ns_sum;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      slew_s  = '0;
      if (state_q == SLEW) begin
         if (rem_q > SLEW_MAX)       slew_s = SLEW_MAX;
         else if (rem_q < -SLEW_MAX) slew_s = -SLEW_MAX;
         else                        slew_s = rem_q;
         rem_d = rem_q - slew_s;
         if (rem_d == 32'sd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end
      // A new offset supersedes whatever is left of the current one.
      if (bus.offset_ld) begin
         rem_d = $signed(bus.offset_ns);
         if (bus.offset_ns != 32'd0) begin
            state_d = SLEW;
            done_d  = 1'b0;
         end else begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end
      if (bus.time_ld) begin
         state_d = IDLE;
         rem_d   = '0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_q    <= PERIOD_RST;
         resid_q     <= '0;
         ns_q        <= '0;
         sec_q       <= '0;
         cap_valid_q <= 1'b0;
         cap_ns_q    <= '0;
         cap_sec_q   <= '0;
         pps_cnt_q   <= '0;
      end else begin
         if (bus.period_ld) period_q <= bus.period_in;
         if (bus.time_ld) begin
            ns_q    <= bus.time_ns_in;
            sec_q   <= bus.time_sec_in;
            resid_q <= '0;
         end else begin
            ns_q    <= ns_wrap[NS_W-1:0];
            resid_q <= resid_sum[RW-1:0];
            if (rollover) sec_q <= sec_q + SEC_W'(1);
         end
         cap_valid_q <= bus.cap_trig;
         if (bus.cap_trig) begin
            cap_ns_q  <= ns_q;
            cap_sec_q <= sec_q;
         end
         if (rollover)               pps_cnt_q <= PW'(PPS_W);
         else if (pps_cnt_q != '0)   pps_cnt_q <= pps_cnt_q - PW'(1);
      end
   end

   assign bus.offset_busy  = (state_q == SLEW);
   assign bus.offset_done  = done_q;
   assign bus.slew_state   = state_q;
   assign bus.cap_valid    = cap_valid_q;
   assign bus.cap_ns       = cap_ns_q;
   assign bus.cap_sec      = cap_sec_q;
   assign bus.time_reg_ns  = ns_q;
   assign bus.time_reg_sec = sec_q;
   assign bus.time_ptp_ns  = {2'b00, ns_q[NS_W-1:FNS_W]};
   assign bus.time_ptp_sec = sec_q;
   assign bus.time_one_pps = (pps_cnt_q != '0);
endmodule

// File: tb/tb_rtc_slew.sv
// Directed bench for rtc_slew: reset, accumulation, rollover/PPS, capture scoreboard,
// slew sequences and their interruptions.
module tb_rtc_slew;
   localparam int SEC_W = 48;
   localparam int FNS_W = 8;
   localparam int PF    = 32;
   localparam int NS_W  = 30 + FNS_W;

   logic clk = 1'b0;
   logic rst = 1'b1;

   rtc_slew_if #(.SEC_W(SEC_W), .FNS_W(FNS_W), .PF(PF)) bus ();

   rtc_slew #(.SEC_W(SEC_W), .FNS_W(FNS_W), .PF(PF), .SLEW_NS(4), .PPS_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int cap_cnt  = 0;
   logic [SEC_W+NS_W-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_time(input logic [SEC_W-1:0] sec, input logic [NS_W-1:0] ns);
      bus.time_ld     = 1'b1;
      bus.time_sec_in = sec;
      bus.time_ns_in  = ns;
      tick();
      bus.time_ld = 1'b0;
   endtask

   task automatic offset(input int off);
      bus.offset_ld = 1'b1;
      bus.offset_ns = off;
      tick();
      bus.offset_ld = 1'b0;
   endtask

   task automatic run_slew(input int off, input int s0, input int s1, input int s2, input string tag);
      int sx[3];
      int d0;
      longint prev, cur;
      sx = '{s0, s1, s2};
      load_time(48'd1, '0);
      d0 = done_cnt;
      offset(off);
      chk({tag, "_busy_start"}, bus.offset_busy, 1);
      prev = longint'(bus.time_reg_ns);
      for (int i = 0; i < 3; i++) begin
         tick();
         cur = longint'(bus.time_reg_ns);
         chk($sformatf("%s_step%0d", tag, i), cur - prev, 2048 + sx[i] * 256);
         chk($sformatf("%s_busy%0d", tag, i), bus.offset_busy, (i < 2) ? 1 : 0);
         chk($sformatf("%s_done%0d", tag, i), bus.offset_done, (i == 2) ? 1 : 0);
         prev = cur;
      end
      tick();
      chk({tag, "_done_end"}, bus.offset_done, 0);
      chk({tag, "_ns_final"}, bus.time_reg_ns, (40 + off) * 256);
      chk({tag, "_done_cnt"}, done_cnt, d0 + 1);
   endtask

   // Capture scoreboard and offset_done pulse counter
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.offset_done) done_cnt++;
         if (bus.cap_valid) begin
            logic [SEC_W+NS_W-1:0] e;
            cap_cnt++;
            chk("cap_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("cap_sec", bus.cap_sec, e[SEC_W+NS_W-1:NS_W]);
               chk("cap_ns", bus.cap_ns, e[NS_W-1:0]);
            end
         end
      end
   end

   initial begin
      int pps_hi;
      int d0;
      logic [NS_W-1:0] ns_pre;
      bus.time_ld     = 1'b0;
      bus.time_ns_in  = '0;
      bus.time_sec_in = '0;
      bus.period_ld   = 1'b0;
      bus.period_in   = '0;
      bus.offset_ld   = 1'b0;
      bus.offset_ns   = '0;
      bus.cap_trig    = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ns", bus.time_reg_ns, 0);
      chk("rst_sec", bus.time_reg_sec, 0);
      chk("rst_busy", bus.offset_busy, 0);
      chk("rst_done", bus.offset_done, 0);
      chk("rst_cap_valid", bus.cap_valid, 0);
      chk("rst_pps", bus.time_one_pps, 0);
      chk("rst_state", bus.slew_state, 0);

      rst = 1'b0;
      repeat (10) tick();
      chk("idle10_ptp_ns", bus.time_ptp_ns, 80);
      chk("idle10_reg_ns", bus.time_reg_ns, 80 * 256);
      chk("idle10_sec", bus.time_reg_sec, 0);
      chk("idle10_ptp_sec", bus.time_ptp_sec, 0);

      // Fractional period: 8 ns + 1/4 fine LSB per cycle
      bus.period_ld = 1'b1;
      bus.period_in = 40'h08_0040_0000;
      load_time('0, '0);
      bus.period_ld = 1'b0;
      chk("frac_load_ns", bus.time_reg_ns, 0);
      repeat (4) tick();
      chk("frac_ns", bus.time_reg_ns, 8193);
      bus.period_ld = 1'b1;
      bus.period_in = {8'd8, 32'd0};
      load_time('0, '0);
      bus.period_ld = 1'b0;

      // Rollover with a capture on the rollover cycle
      ns_pre = NS_W'(longint'(999999992) * 256);
      load_time(48'd5, ns_pre);
      chk("roll_ld_ns", bus.time_reg_ns, ns_pre);
      chk("roll_ld_sec", bus.time_reg_sec, 5);
      chk("roll_ld_pps", bus.time_one_pps, 0);
      bus.cap_trig = 1'b1;
      exp_q.push_back({48'd5, ns_pre});
      tick();
      bus.cap_trig = 1'b0;
      chk("roll_ns", bus.time_reg_ns, 0);
      chk("roll_sec", bus.time_reg_sec, 6);
      chk("roll_pps_first", bus.time_one_pps, 1);
      pps_hi = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.time_one_pps) pps_hi++;
      end
      chk("pps_after", bus.time_one_pps, 0);
      chk("pps_width", pps_hi, 4);

      // Capture together with a load sees the pre-load time
      load_time(48'd7, NS_W'(1000 * 256));
      exp_q.push_back({48'd7, NS_W'(1000 * 256)});
      bus.cap_trig    = 1'b1;
      bus.time_ld     = 1'b1;
      bus.time_sec_in = 48'd9;
      bus.time_ns_in  = NS_W'(5000 * 256);
      tick();
      bus.cap_trig = 1'b0;
      bus.time_ld  = 1'b0;
      chk("capld_ns", bus.time_reg_ns, 5000 * 256);
      chk("capld_sec", bus.time_reg_sec, 9);
      chk("capld_pps", bus.time_one_pps, 0);

      run_slew(10, 4, 4, 2, "slew_pos");
      run_slew(-10, -4, -4, -2, "slew_neg");

      // Zero offset completes immediately
      offset(0);
      chk("zero_done", bus.offset_done, 1);
      chk("zero_busy", bus.offset_busy, 0);
      tick();
      chk("zero_done_end", bus.offset_done, 0);

      // Load mid-slew; a same-cycle offset_ld is ignored
      load_time(48'd2, '0);
      d0 = done_cnt;
      offset(100);
      tick();
      tick();
      bus.offset_ld   = 1'b1;
      bus.offset_ns   = 50;
      bus.time_ld     = 1'b1;
      bus.time_sec_in = 48'd3;
      bus.time_ns_in  = NS_W'(123 * 256);
      tick();
      bus.offset_ld = 1'b0;
      bus.time_ld   = 1'b0;
      chk("ldmid_ns", bus.time_reg_ns, 123 * 256);
      chk("ldmid_sec", bus.time_reg_sec, 3);
      chk("ldmid_busy", bus.offset_busy, 0);
      tick();
      chk("ldmid_ns_next", bus.time_reg_ns, 131 * 256);
      chk("ldmid_done", bus.offset_done, 0);
      tick();
      chk("ldmid_done_cnt", done_cnt, d0);

      // Second offset replaces the first: 4+4+4 from the first, then 4+2
      load_time(48'd4, '0);
      d0 = done_cnt;
      offset(100);
      tick();
      tick();
      offset(6);
      repeat (16) tick();
      chk("reoff_ns", bus.time_reg_ns, 178 * 256);
      chk("reoff_busy", bus.offset_busy, 0);
      chk("reoff_done_cnt", done_cnt, d0 + 1);

      // Reset mid-slew abandons it silently
      offset(100);
      tick();
      chk("rstmid_busy_before", bus.offset_busy, 1);
      d0 = done_cnt;
      #2;
      rst = 1'b1;
      #1;
      chk("rstmid_busy", bus.offset_busy, 0);
      chk("rstmid_done", bus.offset_done, 0);
      chk("rstmid_ns", bus.time_reg_ns, 0);
      chk("rstmid_sec", bus.time_reg_sec, 0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("rstmid_done_cnt", done_cnt, d0);
      chk("rstmid_busy_after", bus.offset_busy, 0);
      chk("rstmid_ns_after", bus.time_reg_ns, 24 * 256);

      chk("cap_q_empty", exp_q.size(), 0);
      chk("cap_count", cap_cnt, 2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
